// File: rtl/serial_link_pkg.sv
// Symbol definitions shared by the serial link transmitter and the receiver/IDL detector,
// so COM and the link states are defined in one place.
package serial_link_pkg;

  localparam int              DATA_W        = 8;
  localparam logic [DATA_W-1:0] COM_SYMBOL  = 8'hBC;
  localparam int              TRAIN_SYMBOLS = 4;

  typedef enum logic {
    TRAIN = 1'b0,
    DATA  = 1'b1
  } link_state_t;

endpackage

// File: rtl/paralelo_serial_tx_if.sv
// Upstream byte handshake into the serial transmitter.
// A byte moves on any clk_32f edge where valid_in and ready_out are both high.
interface paralelo_serial_tx_if;
  import serial_link_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);

endinterface

// File: rtl/paralelo_serial_tx_hold_buf.sv
// One-entry holding register between the upstream handshake and the shifter.
// Written one cycle after push; a push and a pop on the same edge keeps it full with the new byte.
module tx_hold_buf
  import serial_link_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic              full,
  output logic [DATA_W-1:0] hold_dat
);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      full     <= 1'b0;
      hold_dat <= '0;
    end else if (push) begin
      full     <= 1'b1;
      hold_dat <= push_dat;
    end else if (pop) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter, MSB first, COM-filled idle slots and a COM training burst after enable.
// Accepted byte goes out at the next load edge (1..8 cycles); ready_out drops while the hold slot is occupied.
module paralelo_serial_tx
  import serial_link_pkg::*;
#(
  parameter logic [DATA_W-1:0] COM_SYM   = COM_SYMBOL,
  parameter int                TRAIN_LEN = TRAIN_SYMBOLS
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  input  logic                 tx_enable,
  paralelo_serial_tx_if.slave  bus,
  output logic                 data_out,
  output logic                 link_active,
  output logic                 sym_start
);

  localparam int CNT_W = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(TRAIN_LEN - 1);

  logic [2:0]        bit_cnt;
  logic [CNT_W-1:0]  sym_cnt;
  link_state_t       state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] hold_dat;
  logic [DATA_W-1:0] next_sym;
  logic              hold_full;
  logic              load;
  logic              drain;
  logic              ready;
  logic              push;

  // A disabled DATA slot still sends COM, so the hold byte survives retraining.
  assign load     = (bit_cnt == 3'd0);
  assign drain    = load && (state == DATA) && tx_enable && hold_full;
  assign next_sym = drain ? hold_dat : COM_SYM;
  assign ready    = (state == DATA) && tx_enable && (!hold_full || drain);
  assign push     = bus.valid_in && ready;
  assign bus.ready_out = ready;

  tx_hold_buf u_hold (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .push     (push),
    .push_dat (bus.data_in),
    .pop      (drain),
    .full     (hold_full),
    .hold_dat (hold_dat)
  );

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= 3'd0;
      sym_cnt     <= '0;
      state       <= TRAIN;
      shift_reg   <= COM_SYM;
      data_out    <= 1'b0;
      sym_start   <= 1'b0;
      link_active <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (load) begin
        shift_reg <= next_sym;
        data_out  <= next_sym[DATA_W-1];
        sym_start <= 1'b1;
        case (state)
          TRAIN: begin
            if (!tx_enable) begin
              sym_cnt <= '0;
            end else if (sym_cnt == LAST_SYM) begin
              state       <= DATA;
              sym_cnt     <= '0;
              link_active <= 1'b1;
            end else begin
              sym_cnt <= sym_cnt + CNT_W'(1);
            end
          end
          DATA: begin
            if (!tx_enable) begin
              state       <= TRAIN;
              sym_cnt     <= '0;
              link_active <= 1'b0;
            end
          end
          default: state <= TRAIN;
        endcase
      end else begin
        data_out  <= shift_reg[3'(DATA_W - 1) - bit_cnt];
        sym_start <= 1'b0;
      end
    end
  end

endmodule
